// File: rtl/fifo_ecc_pkg.sv
// Shared ECC definitions for the FIFO write-side encoder and read-side decoder.
// Both ends call ecc_calc so their check-bit rules cannot drift apart.
package fifo_ecc_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ECC_WIDTH  = 5;
    localparam int CALC_DATA_W    = 32;
    localparam int CALC_ECC_W     = 5;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'b00,
        SKID_MAIN  = 2'b10,
        SKID_FULL  = 2'b11
    } skid_state_t;

    // Bit j feeds check bit i when index j has bit i set; data[0] feeds none.
    function automatic logic [CALC_ECC_W-1:0] ecc_calc(
        input logic [CALC_DATA_W-1:0] data
    );
        logic [CALC_ECC_W-1:0] e;
        e = '0;
        for (int j = 0; j < CALC_DATA_W; j++) begin
            for (int i = 0; i < CALC_ECC_W; i++) begin
                if (j[i]) e[i] = e[i] ^ data[j];
            end
        end
        return e;
    endfunction

endpackage

// File: rtl/ecc_skid_buf.sv
// Two-entry valid/ready buffer: main register drives the outputs,
// skid register absorbs the word in flight when the sink stalls.
module ecc_skid_buf
    import fifo_ecc_pkg::*;
#(
    parameter int W = 37
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    skid_state_t state, state_nxt;
    logic [W-1:0] main_q, skid_q;
    logic accept, present;

    assign accept  = in_valid && in_ready;
    assign present = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= SKID_EMPTY;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            SKID_EMPTY: if (accept) state_nxt = SKID_MAIN;
            SKID_MAIN: begin
                if (accept && !present)      state_nxt = SKID_FULL;
                else if (present && !accept) state_nxt = SKID_EMPTY;
            end
            SKID_FULL: if (present) state_nxt = SKID_MAIN;
            default: state_nxt = SKID_EMPTY;
        endcase
    end

    // in_ready depends only on the state register, never on out_ready.
    always_comb begin
        in_ready  = (state != SKID_FULL);
        out_valid = (state != SKID_EMPTY);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (state == SKID_FULL && present)
                main_q <= skid_q;
            else if (accept && (state == SKID_EMPTY || present))
                main_q <= in_data;
            if (accept && state == SKID_MAIN && !present)
                skid_q <= in_data;
        end
    end

    assign out_data = main_q;

endmodule

// File: rtl/ecc_encode_stage.sv
// Write-side Hamming ECC encoder with debug single-bit error injection
// and a wrapping count of words handed to the FIFO.
module ecc_encode_stage
    import fifo_ecc_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ECC_WIDTH  = DEF_ECC_WIDTH,
    parameter int CNT_WIDTH  = 16,
    parameter int IDX_WIDTH  = $clog2(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  inj_en,
    input  logic [IDX_WIDTH-1:0]  inj_bit,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ECC_WIDTH-1:0]  out_ecc,
    output logic [CNT_WIDTH-1:0]  enc_count
);

    localparam int W = DATA_WIDTH + ECC_WIDTH;

    logic [ECC_WIDTH-1:0]  ecc;
    logic [DATA_WIDTH-1:0] flip;
    logic [W-1:0]          buf_out;

    assign ecc = ECC_WIDTH'(ecc_calc(CALC_DATA_W'(in_data)));

    // Out-of-range indices match no bit, so injection is suppressed.
    always_comb begin
        flip = '0;
        for (int j = 0; j < DATA_WIDTH; j++) begin
            flip[j] = inj_en && (inj_bit == IDX_WIDTH'(j));
        end
    end

    ecc_skid_buf #(
        .W(W)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  ({in_data ^ flip, ecc}),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (buf_out)
    );

    assign out_data = buf_out[W-1:ECC_WIDTH];
    assign out_ecc  = buf_out[ECC_WIDTH-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                        enc_count <= '0;
        else if (out_valid && out_ready) enc_count <= enc_count + 1'b1;
    end

endmodule

// File: tb/tb_ecc_encode_stage.sv
// Scoreboard bench for ecc_encode_stage: expected words queued on accept,
// compared on each output handshake; a CNT_WIDTH=4 twin covers wrap.
module tb_ecc_encode_stage;

    typedef struct {
        logic [31:0] d;
        logic [4:0]  e;
    } exp_t;

    logic        clk = 0;
    logic        rst = 1;
    logic        in_valid = 0;
    logic [31:0] in_data = '0;
    logic        inj_en = 0;
    logic [4:0]  inj_bit = '0;
    logic        out_ready = 0;
    logic        in_ready, out_valid;
    logic [31:0] out_data;
    logic [4:0]  out_ecc;
    logic [15:0] enc_count;
    logic        in_ready4, out_valid4;
    logic [31:0] out_data4;
    logic [4:0]  out_ecc4;
    logic [3:0]  enc_count4;

    int   n_pass = 0;
    int   n_total = 0;
    int   cyc = 0;
    bit   tp_mode = 0;
    bit   hold_v = 0;
    logic [36:0] hold_word;
    exp_t q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    ecc_encode_stage dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .inj_en(inj_en), .inj_bit(inj_bit),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_ecc(out_ecc), .enc_count(enc_count)
    );

    ecc_encode_stage #(.CNT_WIDTH(4)) dut4 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready4), .in_data(in_data),
        .inj_en(inj_en), .inj_bit(inj_bit),
        .out_valid(out_valid4), .out_ready(out_ready),
        .out_data(out_data4), .out_ecc(out_ecc4), .enc_count(enc_count4)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic exp_t model(input logic [31:0] d, input logic ie,
                                   input logic [4:0] ib);
        exp_t r;
        logic [31:0] m;
        for (int i = 0; i < 5; i++) begin
            m = '0;
            for (int j = 0; j < 32; j++) m[j] = ((j >> i) & 1) == 1;
            r.e[i] = ^(d & m);
        end
        r.d = ie ? (d ^ (32'h1 << ib)) : d;
        return r;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            hold_v = 0;
        end else begin
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("sb_underflow", 32'(q.size()), 1);
                end else begin
                    e = q.pop_front();
                    chk("sb_data", out_data, e.d);
                    chk("sb_ecc", 32'(out_ecc), 32'(e.e));
                end
            end
            if (hold_v && out_valid)
                chk("hold", 32'({out_data, out_ecc} != hold_word), 0);
            hold_v = out_valid && !out_ready;
            hold_word = {out_data, out_ecc};
            if (in_valid && in_ready)
                q.push_back(model(in_data, inj_en, inj_bit));
            if (tp_mode) chk("tp_in_ready", 32'(in_ready), 1);
        end
    end

    task automatic do_reset();
        in_valid = 0;
        inj_en = 0;
        rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        q.delete();
    endtask

    task automatic send(input logic [31:0] d, input logic ie,
                        input logic [4:0] ib);
        int n = 0;
        in_valid = 1;
        in_data = d;
        inj_en = ie;
        inj_bit = ib;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("send_timeout", 32'(in_ready), 1);
        @(posedge clk);
        #1;
    endtask

    logic [31:0] vec_d[4] = '{32'h1, 32'hA, 32'h8000_0000, 32'hFFFF_FFFF};
    logic [4:0]  vec_e[4] = '{5'h00, 5'h02, 5'h1F, 5'h00};

    initial begin
        int t0, n;
        logic [31:0] syn;
        exp_t s;

        @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_data", out_data, 0);
        chk("rst_count", 32'(enc_count), 0);
        do_reset();

        out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            send(vec_d[i], 0, 0);
            in_valid = 0;
            chk("vec_valid", 32'(out_valid), 1);
            chk("vec_data", out_data, vec_d[i]);
            chk("vec_ecc", 32'(out_ecc), 32'(vec_e[i]));
        end
        @(posedge clk);
        #1;

        do_reset();
        out_ready = 0;
        send(32'h11, 0, 0);
        send(32'h22, 0, 0);
        chk("bp_in_ready", 32'(in_ready), 0);
        chk("bp_out_data", out_data, 32'h11);
        out_ready = 1;
        send(32'h33, 0, 0);
        in_valid = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("bp_count", 32'(enc_count), 3);

        out_ready = 0;
        send(32'h44, 0, 0);
        send(32'h55, 0, 0);
        in_valid = 0;
        #2 rst = 1;
        #1;
        chk("arst_out_valid", 32'(out_valid), 0);
        chk("arst_in_ready", 32'(in_ready), 1);
        chk("arst_out_data", out_data, 0);
        chk("arst_out_ecc", 32'(out_ecc), 0);
        chk("arst_count", 32'(enc_count), 0);
        do_reset();

        out_ready = 1;
        tp_mode = 1;
        t0 = cyc;
        for (int i = 0; i < 100; i++) send($urandom, 0, 0);
        chk("tp_cycles", 32'(cyc - t0), 100);
        tp_mode = 0;
        in_valid = 0;
        @(posedge clk);
        #1;
        chk("tp_count", 32'(enc_count), 100);
        chk("tp_count4", 32'(enc_count4), 4);

        do_reset();
        out_ready = 1;
        send(32'h0, 1, 5);
        in_valid = 0;
        chk("inj_data", out_data, 32'h20);
        chk("inj_ecc", 32'(out_ecc), 0);
        s = model(out_data, 0, 0);
        syn = 32'(s.e ^ out_ecc);
        chk("inj_syndrome", syn, 5);
        @(posedge clk);
        #1;

        do_reset();
        out_ready = 1;
        for (int i = 0; i < 17; i++) send(32'(i * 7), 0, 0);
        in_valid = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("wrap_count4", 32'(enc_count4), 1);
        chk("wrap_count", 32'(enc_count), 17);

        for (int i = 0; i < 400; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data = $urandom;
            inj_en = ($urandom_range(0, 3) == 0);
            inj_bit = 5'($urandom_range(0, 31));
            out_ready = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
        in_valid = 0;
        inj_en = 0;
        out_ready = 1;
        n = 0;
        while (q.size() != 0 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        @(negedge clk);
        chk("drain_empty", 32'(q.size()), 0);
        chk("drain_out_valid", 32'(out_valid), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ecc_encode_stage.md
Name: ecc_encode_stage

Overview:
- Write-side Hamming ECC encoder for the FIFO datapath; the counterpart of the read-side ECC decoder.
- Accepts data words over a valid/ready handshake and computes the check bits.
- Presents data plus check bits, registered, to the FIFO write port.
- Includes a 2-entry skid buffer for full throughput under backpressure, a debug single-bit error-injection path for exercising the decoder, and a wrapping encoded-word counter.

Parameters:
- DATA_WIDTH, 32, data word width; legal range 2..32.
- ECC_WIDTH, 5, check-bit count; must satisfy 2**ECC_WIDTH >= DATA_WIDTH.
- CNT_WIDTH, 16, width of the encoded-word counter.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream word valid.
- in_ready  out  1  stage can accept a word.
- in_data  in  DATA_WIDTH  upstream word.
- inj_en  in  1  sampled with in_data; flip one stored data bit of this word.
- inj_bit  in  $clog2(DATA_WIDTH)  index of the bit to flip when inj_en=1.
- out_valid  out  1  encoded word valid to FIFO.
- out_ready  in  1  FIFO can accept (i.e. !full).
- out_data  out  DATA_WIDTH  data to FIFO (possibly error-injected).
- out_ecc  out  ECC_WIDTH  check bits to FIFO.
- enc_count  out  CNT_WIDTH  number of output handshakes, mod 2**CNT_WIDTH.

Behaviour:
- Reset (async assert, sync-released state): out_valid=0, in_ready=1, out_data=0, out_ecc=0, enc_count=0, skid empty. Reset mid-transfer discards both buffered words; no partial word is presented.
- Check-bit function: ecc[i] = XOR of data[j] for all j in 0..DATA_WIDTH-1 whose binary index has bit i set. data[0] is covered by no check bit; this is intended and must match the decoder exactly.
- ECC is computed on the unmodified in_data. Injection flips data[inj_bit] after ECC computation, so the decoder sees a single-bit error at syndrome = inj_bit.
- inj_bit >= DATA_WIDTH: injection suppressed.
- Accept: in_valid && in_ready. Present: out_valid && out_ready.
- Latency: a word accepted in cycle N appears on out_data/out_ecc with out_valid=1 in cycle N+1 when the main register is free or draining.
- Storage: main register (drives outputs) plus one skid register. in_ready = !skid_valid, registered with no combinational path from out_ready.
- Transitions (state = {main_valid, skid_valid}):
  - EMPTY {0,0}: accept -> MAIN.
  - MAIN {1,0}: accept & present -> MAIN (main reloads); accept & !present -> FULL (word into skid); present & !accept -> EMPTY.
  - FULL {1,1}: no accept (in_ready=0); present -> MAIN (skid moves to main).
- Ordering is strictly FIFO; no word is dropped or duplicated.
- out_data/out_ecc hold stable while out_valid=1 && out_ready=0.
- enc_count increments by 1 on each present, wraps from all-ones to 0 with no flag, and is unaffected by injection.
- in_valid may drop without acceptance. in_data is don't-care when in_valid=0.

Decomposition:
- Shared package fifo_ecc_pkg:
  - DATA_WIDTH/ECC_WIDTH defaults.
  - Function ecc_calc(data) implementing the check-bit rule, used by both this encoder and the decoder so the two ends cannot drift.
- One sub-module: ecc_skid_buf, a parameterised 2-entry valid/ready buffer carrying {data, ecc}.
- Encoder logic and counter stay in ecc_encode_stage.

Test Plan:
- Reset: assert rst async mid-cycle with words buffered -> outputs zero, out_valid=0, in_ready=1, enc_count=0 immediately.
- Known vectors, out_ready=1:
  - 0x00000001 -> ecc 0x00
  - 0x0000000A -> ecc 0x02
  - 0x80000000 -> ecc 0x1F
  - 0xFFFFFFFF -> ecc 0x00
  - each appears one cycle after acceptance.
- Backpressure: stream 0x11,0x22,0x33 with out_ready=0 -> in_ready drops after 2 accepts, out holds 0x11. Release out_ready -> 0x11,0x22,0x33 emitted in order; enc_count=3.
- Full throughput: continuous in_valid/out_ready=1 for 100 words -> one word per cycle, enc_count=100, in_ready never deasserts.
- Injection: in_data=0x00000000, inj_en=1, inj_bit=5 -> out_data=0x00000020, out_ecc=0x00. Decoder syndrome = 5.
- Counter wrap: CNT_WIDTH=4, 17 presents -> enc_count=1.
